// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial shift engines: the mode encoding and
// an elaboration-time ceiling-log2 helper.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Ceiling log2, evaluated at elaboration time only (bounded loop).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_word_counter.sv
// Counts qualified shifts and emits a registered one-cycle pulse on the edge
// that completes each WIDTH-shift word; clear restarts the word.
module shift_word_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic done_pulse
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make update order significant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc) begin
      // Wrap straight to zero so back-to-back words need no gap cycle.
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done_pulse = r_done;

endmodule

// File: rtl/shift_register_param.sv
// Parametrised bidirectional shift register with parallel load, serial-out
// taps and a word-complete pulse for serialiser/deserialiser use.
module shift_register_param
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 14,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             d,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic             word_done
);

  logic [WIDTH-1:0] r_q;
  logic             w_shift;
  logic             w_load;

  assign w_shift = enable && ((mode == MODE_UP) || (mode == MODE_DOWN));
  assign w_load  = enable && (mode == MODE_LOAD);

  // One registered mux per bit; every mode value is decoded explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (enable) begin
      case (mode)
        MODE_HOLD: r_q <= r_q;
        MODE_UP:   r_q <= {r_q[WIDTH-2:0], d};
        MODE_DOWN: r_q <= {d, r_q[WIDTH-1:1]};
        MODE_LOAD: r_q <= load_data;
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH(WIDTH)
  ) u_word_counter (
    .clk       (clk),
    .reset     (reset),
    .inc       (w_shift),
    .clear     (w_load),
    .done_pulse(word_done)
  );

  assign q       = r_q;
  assign sout_hi = r_q[WIDTH-1];
  assign sout_lo = r_q[0];

endmodule

// File: tb/tb_shift_register_param.sv
// Scoreboard bench: the driver pushes reference-model expectations, a monitor
// pops and compares one entry per clock after the edge settles.
module tb_shift_register_param;
  import shift_reg_pkg::*;

  localparam int          W  = 14;
  localparam logic [13:0] RV = 14'h0155;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic          d;
  logic [W-1:0]  load_data;
  logic [W-1:0]  q;
  logic          sout_hi;
  logic          sout_lo;
  logic          word_done;

  shift_register_param #(
    .WIDTH      (W),
    .RESET_VALUE(RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .d        (d),
    .load_data(load_data),
    .q        (q),
    .sout_hi  (sout_hi),
    .sout_lo  (sout_lo),
    .word_done(word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         done;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: value as an integer, shifts since last restart.
  logic [W-1:0] m_q;
  int           m_shifts;
  logic         m_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [1:0] md,
                     input logic dd, input logic [W-1:0] ld, input string tag);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    enable    = en;
    mode      = md;
    d         = dd;
    load_data = ld;
    if (rst) begin
      m_q = RV; m_shifts = 0; m_done = 1'b0;
    end else if (!en || md == MODE_HOLD) begin
      m_done = 1'b0;
    end else if (md == MODE_LOAD) begin
      m_q = ld; m_shifts = 0; m_done = 1'b0;
    end else begin
      if (md == MODE_UP) m_q = (m_q << 1) | W'(dd);
      else               m_q = (m_q >> 1) | (W'(dd) << (W - 1));
      m_shifts = m_shifts + 1;
      m_done   = (m_shifts % W) == 0;
      if (m_done) m_shifts = 0;
    end
    e.q = m_q; e.done = m_done; e.tag = tag;
    exp_q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".q"},         64'(q),         64'(e.q));
      check({e.tag, ".sout_hi"},   64'(sout_hi),   64'(e.q[W-1]));
      check({e.tag, ".sout_lo"},   64'(sout_lo),   64'(e.q[0]));
      check({e.tag, ".word_done"}, 64'(word_done), 64'(e.done));
    end
  end

  initial begin
    logic [1:0] rm;
    reset = 1'b1; enable = 1'b0; mode = MODE_HOLD; d = 1'b0; load_data = '0;
    m_q = RV; m_shifts = 0; m_done = 1'b0;

    cyc(1, 0, MODE_HOLD, 0, '0, "reset");
    cyc(0, 0, MODE_HOLD, 0, '0, "idle");

    // Fill with ones from zero: pulse only after the 14th shift.
    cyc(0, 1, MODE_LOAD, 0, 14'h0000, "clr");
    for (int i = 0; i < W; i++) cyc(0, 1, MODE_UP, 1, '0, "fill_up");
    cyc(0, 1, MODE_HOLD, 0, '0, "fill_after");

    // Load then one shift-down with d=1.
    cyc(0, 1, MODE_LOAD, 0, 14'h2A5C, "load");
    cyc(0, 1, MODE_DOWN, 1, '0, "down1");

    // Enable gap mid-word, mixed directions.
    cyc(0, 1, MODE_LOAD, 0, 14'h0000, "gap_ld");
    for (int i = 0; i < 5; i++) cyc(0, 1, MODE_UP, i[0], '0, "gap_pre");
    for (int i = 0; i < 3; i++) cyc(0, 0, MODE_UP, 1, '0, "gap_hold");
    for (int i = 0; i < 9; i++) cyc(0, 1, (i < 4) ? MODE_DOWN : MODE_UP, ~i[0], '0, "gap_post");

    // Load mid-word restarts the count.
    for (int i = 0; i < 7; i++) cyc(0, 1, MODE_UP, 1, '0, "mid_pre");
    cyc(0, 1, MODE_LOAD, 0, 14'h0000, "mid_ld");
    for (int i = 0; i < W; i++) cyc(0, 1, MODE_DOWN, 1, '0, "mid_post");

    // Reset wins over load on the same edge, then two back-to-back words.
    for (int i = 0; i < 3; i++) cyc(0, 1, MODE_UP, 1, '0, "rst_pre");
    cyc(1, 1, MODE_LOAD, 0, 14'h3ABC, "rst_vs_ld");
    for (int i = 0; i < 2 * W; i++) cyc(0, 1, MODE_UP, i[1], '0, "b2b");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rm = 2'($urandom_range(0, 9) < 7 ? $urandom_range(1, 2) : $urandom_range(0, 3));
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0), rm,
          1'($urandom), W'($urandom), "rand");
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- Parametrised successor to the fixed 14-bit enabled shift register used for serial capture in the embedded datapath.
- Adds bidirectional shifting, parallel load, serial-out taps and a word-complete counter.
- Can act as serialiser or deserialiser for peripheral links (e.g. SPI-style sensor/DAC streams) without a separate bit counter.
- Sits between the serial pin logic and the word-wide control/data registers.

Parameters:
- WIDTH, 14, register width in bits; legal range 2..64.
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).
- CNT_W, clog2(WIDTH+1), localparam (derived, not overridable): width of the internal shift counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  qualifies all state updates except reset.
- mode  input  2  operation select: 00 hold, 01 shift-up, 10 shift-down, 11 parallel load.
- d  input  1  serial data in, used by both shift modes.
- load_data  input  WIDTH  parallel load value.
- q  output  WIDTH  register contents.
- sout_hi  output  1  equals q[WIDTH-1]; serial out for shift-up.
- sout_lo  output  1  equals q[0]; serial out for shift-down.
- word_done  output  1  one-cycle pulse: WIDTH shifts completed since the last load or reset.

Behaviour:
- All state changes on rising clk. Reset has priority over every other input.
- Reset values: q=RESET_VALUE, internal count=0, word_done=0. sout_hi and sout_lo follow q combinationally.
- enable=0 or mode=00:
  - q and count hold.
  - word_done is 0 on the next cycle, so the pulse is never stretched.
- mode=01 (shift-up): q[0]<=d; q[i]<=q[i-1] for i=1..WIDTH-1. This matches the legacy bit ordering.
- mode=10 (shift-down): q[WIDTH-1]<=d; q[i]<=q[i+1] for i=0..WIDTH-2.
- mode=11 (parallel load): q<=load_data; count<=0; word_done<=0.
- Counting: each enabled shift (mode 01 or 10) increments count.
  - The shift that brings count to WIDTH sets count<=0 and word_done<=1. word_done is registered and high for exactly the one cycle after that edge.
  - All other enabled cycles set word_done<=0.
- Direction change mid-word: count continues. Shifts in either direction count equally.
- Back-to-back words: continuous shifting gives a word_done pulse every WIDTH cycles with no gap cycle.
- Reset mid-word: count is discarded and the next word_done needs WIDTH fresh shifts.
- Load mid-word: identical restart to reset for counting; q takes load_data.
- Latency: q reflects d or load_data one clock after the enabling edge. sout_* have zero added latency from q.
- No X propagation: mode is fully decoded, with no default-to-X branch.

Decomposition:
- Shared package shift_reg_pkg holds the mode constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11, and a clog2 function for CNT_W.
- One natural sub-module: shift_word_counter.
  - Parameter WIDTH.
  - Inputs clk, reset, inc, clear.
  - Output done_pulse.
  - Reused by future serial engines.
- The datapath stays in the top level as a single registered mux per bit. There are no per-bit flip-flop instances.

Test Plan:
- Reset with WIDTH=14, RESET_VALUE=14'h0155 -> after one edge q=14'h0155, sout_lo=1, sout_hi=0, word_done=0.
- From q=0: mode=01, d=1, 14 enabled cycles -> q=14'h3FFF after the 14th edge; word_done=1 for exactly that following cycle and 0 before and after.
- Load 14'h2A5C, then one mode=10 shift with d=1 -> q=14'h352E. Before the shift sout_lo=0 and sout_hi=1.
- 5 shifts, enable=0 for 3 cycles, then 9 more shifts -> q held during the gap; word_done pulses only after the 14th shift, with no pulse during the gap.
- 7 shifts, then a load of 14'h0000, then 14 shifts -> no word_done after the first 7; a single pulse after the 14th post-load shift.
- Reset asserted with mode=11 and enable=1 on the same edge -> q=RESET_VALUE (reset wins); 28 continuous shifts then produce two word_done pulses exactly 14 cycles apart.
